mul_result_packer: RTL and testbench
====================================

# mul_result_packer

Downstream stage of the vector multiplier. Takes the full-width, per-lane products the multiplier emits each beat, selects the low or high half of every element per SEW, and packs the results into 32-bit destination words with byte enables. Words are buffered in a small FIFO and handed to the register-file writeback port over a valid/ready handshake. An element counter driven by `vl` flags the last word and masks tail elements.

## Interface
- `FIFO_DEPTH`, 4: output buffer entries (power of two, ≥2)
- `VL_W`, 9: width of the `vl` element count
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse; latches `vl`, `sew`, `high_sel`
- `vl`  in  VL_W  element count for this operation
- `sew`  in  2  00=8b, 01=16b, 10=32b, 11 treated as 10
- `high_sel`  in  1  1=upper half of each product (vmulh), 0=lower (vmul)
- `in_valid`  in  1  multiplier product beat valid
- `in_ready`  out  1  packer accepts beat
- `prod_in`  in  64  lane products: sew00 four 16b at [16k+15:16k]; sew01 two 32b at [32k+31:32k]; sew10 one 64b
- `out_valid`  out  1  word available
- `out_ready`  in  1  writeback accepts word
- `out_data`  out  32  packed result word
- `out_be`  out  4  byte enables
- `out_last`  out  1  final word of operation
- `busy`  out  1  state ≠ IDLE
- `done`  out  1  one-cycle pulse at completion

## Operation
- Elements per word E = 4/2/1 (sew 00/01/10); words W = ceil(vl/E); one input beat → one output word.
- Packing, lane k: sew00 byte k = `high_sel` ? p[15:8] : p[7:0]; sew01 half k = p[31:16] : p[15:0]; sew10 word = p[63:32] : p[31:0].
- States: IDLE → (start, vl≠0) RUN → (accepted==W) DRAIN → (FIFO empty) IDLE with `done`. start with vl=0: `done` next cycle, stays IDLE, no output.
- `start` ignored outside IDLE.
- `in_ready` = RUN && !full && accepted<W. Beats with `in_valid` outside RUN are ignored (not consumed).
- Last word: remaining r = vl − (W−1)·E; `out_be` enables r elements from byte 0 (sew00: low r bits; sew01 r=1: 4'b0011; sew10: 4'hF); disabled bytes driven 0. Other words: `out_be`=4'hF, `out_last`=0.
- FIFO preserves order; entry = {data, be, last}.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `out_data`=0, `out_be`=0, `out_last`=0, `busy`=0, `done`=0; state IDLE, counters and FIFO pointers 0.
- `busy`=1 the cycle after `start`; `in_ready` may assert that same cycle.
- Beat accepted at edge N appears on `out_data` with `out_valid` after edge N (visible cycle N+1) if FIFO was empty.
- Word leaves on `out_valid && out_ready`; outputs held stable while `out_ready`=0.
- Full: `in_ready`=0 even if a pop occurs same cycle (no bypass). Simultaneous push and pop when not full: count unchanged.
- `done` asserts the cycle after the last word pops; `busy` falls with it.
- Reset mid-operation: FIFO flushed, pending words lost, no `done`.

## Configuration
- `MUL_PACK_HIGH_EN` defined: `high_sel` honoured as above.
- Undefined: `high_sel` ignored, low half always selected; high-half mux logic not built.

## Test plan
- sew=01, vl=2, high_sel=0, prod_in=64'h0000_0006_0000_0018 → one word 32'h0006_0018, be=4'hF, last=1, then done pulse.
- sew=01, vl=2, high_sel=1, prod_in=64'h1234_5678_9ABC_DEF0 → 32'h1234_9ABC (without macro: 32'h5678_DEF0).
- sew=00, vl=6, two beats of 64'h0102_0304_0506_0708 → 32'h0204_0608 be=4'hF last=0; 32'h0000_0608 be=4'b0011 last=1.
- Backpressure: sew=10, vl=6, out_ready=0 → 4 beats accepted, in_ready low; release → six words in order, last on sixth.
- start with vl=0 → done one cycle later, out_valid never asserts, busy stays 0.
- reset low mid-RUN after 2 beats → all outputs to reset values immediately; no done; next start operates cleanly.

Source files
------------

// File: rtl/mul_result_packer.sv
// mul_result_packer: picks the low/high half of each lane product per SEW, packs the results into
// 32-bit words with byte enables, and buffers them for writeback. Optional feature: MUL_PACK_HIGH_EN.
module mul_result_packer #(
  parameter int FIFO_DEPTH = 4,
  parameter int VL_W       = 9
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [VL_W-1:0] vl,
  input  logic [1:0]      sew,
  input  logic            high_sel,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [63:0]     prod_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_data,
  output logic [3:0]      out_be,
  output logic            out_last,
  output logic            busy,
  output logic            done
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | accepting product beats, one word per beat
  // DRAIN | every beat taken, waiting for the FIFO to empty
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [VL_W:0]  ROUND_4  = (VL_W+1)'(3);
  localparam logic [VL_W:0]  ROUND_2  = (VL_W+1)'(1);

  state_t          state;
  logic [1:0]      sew_q;
  logic [VL_W-1:0] beats_left;
  logic [3:0]      last_be_q;
  logic [1:0]      sew_norm;
  logic [VL_W:0]   vl_ext;
  logic [VL_W-1:0] words_calc;
  logic [3:0]      last_be_calc;
  logic [31:0]     pack_data;
  logic [31:0]     word_data;
  logic [3:0]      word_be;
  logic            word_last;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;

  logic [31:0]     mem_data [FIFO_DEPTH];
  logic [3:0]      mem_be   [FIFO_DEPTH];
  logic            mem_last [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

`ifdef MUL_PACK_HIGH_EN
  logic high_q;
`endif

  assign sew_norm = (sew == 2'b11) ? 2'b10 : sew;
  assign vl_ext   = {1'b0, vl};

  // Word count and the byte enables of the final word are fixed at start.
  always_comb begin
    words_calc   = vl;
    last_be_calc = 4'hF;
    case (sew_norm)
      2'b00: begin
        words_calc = VL_W'((vl_ext + ROUND_4) >> 2);
        case (vl[1:0])
          2'b01:   last_be_calc = 4'b0001;
          2'b10:   last_be_calc = 4'b0011;
          2'b11:   last_be_calc = 4'b0111;
          default: last_be_calc = 4'hF;
        endcase
      end
      2'b01: begin
        words_calc   = VL_W'((vl_ext + ROUND_2) >> 1);
        last_be_calc = vl[0] ? 4'b0011 : 4'hF;
      end
      default: begin
        words_calc   = vl;
        last_be_calc = 4'hF;
      end
    endcase
  end

`ifdef MUL_PACK_HIGH_EN
  always_comb begin
    pack_data = '0;
    case (sew_q)
      2'b00: for (int k = 0; k < 4; k++)
               pack_data[8*k +: 8] = high_q ? prod_in[16*k+8 +: 8] : prod_in[16*k +: 8];
      2'b01: for (int k = 0; k < 2; k++)
               pack_data[16*k +: 16] = high_q ? prod_in[32*k+16 +: 16] : prod_in[32*k +: 16];
      default: pack_data = high_q ? prod_in[63:32] : prod_in[31:0];
    endcase
  end
`else
  // Low halves only; high_sel and the top product byte have no consumer in this build.
  logic unused_bits;
  assign unused_bits = ^{high_sel, prod_in[63:56]};

  always_comb begin
    pack_data = '0;
    case (sew_q)
      2'b00: for (int k = 0; k < 4; k++)
               pack_data[8*k +: 8] = prod_in[16*k +: 8];
      2'b01: for (int k = 0; k < 2; k++)
               pack_data[16*k +: 16] = prod_in[32*k +: 16];
      default: pack_data = prod_in[31:0];
    endcase
  end
`endif

  assign word_last = (beats_left == VL_W'(1));
  assign word_be   = word_last ? last_be_q : 4'hF;

  always_comb begin
    word_data = '0;
    for (int b = 0; b < 4; b++)
      word_data[8*b +: 8] = word_be[b] ? pack_data[8*b +: 8] : 8'h00;
  end

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign in_ready = (state == RUN) && !full && (beats_left != '0);
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      sew_q      <= 2'b00;
      beats_left <= '0;
      last_be_q  <= 4'h0;
      done       <= 1'b0;
`ifdef MUL_PACK_HIGH_EN
      high_q     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (vl == '0) begin
              done <= 1'b1;
            end else begin
              state      <= RUN;
              sew_q      <= sew_norm;
              beats_left <= words_calc;
              last_be_q  <= last_be_calc;
`ifdef MUL_PACK_HIGH_EN
              high_q     <= high_sel;
`endif
            end
          end
        end
        RUN: begin
          if (push) begin
            beats_left <= beats_left - 1'b1;
            if (word_last) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (empty || (count == (PTR_W+1)'(1) && pop)) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= word_data;
      mem_be[wr_ptr]   <= word_be;
      mem_last[wr_ptr] <= word_last;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset, so outputs are forced to zero whenever nothing is queued.
  assign out_valid = !empty;
  assign out_data  = empty ? 32'h0 : mem_data[rd_ptr];
  assign out_be    = empty ? 4'h0  : mem_be[rd_ptr];
  assign out_last  = empty ? 1'b0  : mem_last[rd_ptr];

endmodule

// File: tb/tb_mul_result_packer.sv
// Directed bench for mul_result_packer: one task per scenario with hand-computed expectations.
module tb_mul_result_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  vl = '0;
  logic [1:0]  sew = '0;
  logic        high_sel = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] prod_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [3:0]  out_be;
  logic        out_last;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mul_result_packer #(.FIFO_DEPTH(4), .VL_W(9)) dut (
    .clk(clk), .reset(reset), .start(start), .vl(vl), .sew(sew), .high_sel(high_sel),
    .in_valid(in_valid), .in_ready(in_ready), .prod_in(prod_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_be(out_be),
    .out_last(out_last), .busy(busy), .done(done)
  );

  task automatic do_start(input logic [8:0] v, input logic [1:0] s, input logic h);
    @(negedge clk);
    start = 1'b1; vl = v; sew = s; high_sel = h;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    n_cmp++;
    if ({in_ready, out_valid, out_data, out_be, out_last, busy, done} !== 41'h0) begin
      n_bad++;
      $display("FAIL reset_values: got rdy=%b vld=%b data=%h be=%h last=%b busy=%b done=%b, want all 0",
               in_ready, out_valid, out_data, out_be, out_last, busy, done);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_sew16_low;
    do_start(9'd2, 2'b01, 1'b0);
    n_cmp++;
    if ({busy, in_ready} !== 2'b11) begin
      n_bad++; $display("FAIL s16_busy_ready: got busy=%b rdy=%b, want 1 1", busy, in_ready);
    end
    in_valid = 1'b1; prod_in = 64'h0000_0006_0000_0018;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, out_data, out_be, out_last} !== {1'b1, 32'h0006_0018, 4'hF, 1'b1}) begin
      n_bad++; $display("FAIL s16_word: got vld=%b data=%h be=%h last=%b, want 1 00060018 f 1",
                        out_valid, out_data, out_be, out_last);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if ({done, busy, out_valid} !== 3'b100) begin
      n_bad++; $display("FAIL s16_done: got done=%b busy=%b vld=%b, want 1 0 0", done, busy, out_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++; $display("FAIL s16_done_pulse: got done=%b, want 0", done);
    end
  endtask

  task automatic test_sew16_high;
    logic [31:0] exp_w;
`ifdef MUL_PACK_HIGH_EN
    exp_w = 32'h1234_9ABC;
`else
    exp_w = 32'h5678_DEF0;
`endif
    do_start(9'd2, 2'b01, 1'b1);
    in_valid = 1'b1; prod_in = 64'h1234_5678_9ABC_DEF0;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, out_data, out_be, out_last} !== {1'b1, exp_w, 4'hF, 1'b1}) begin
      n_bad++; $display("FAIL s16_high_word: got vld=%b data=%h be=%h last=%b, want 1 %h f 1",
                        out_valid, out_data, out_be, out_last, exp_w);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if ({done, busy} !== 2'b10) begin
      n_bad++; $display("FAIL s16_high_done: got done=%b busy=%b, want 1 0", done, busy);
    end
  endtask

  task automatic test_sew8_tail;
    do_start(9'd6, 2'b00, 1'b0);
    out_ready = 1'b1;
    in_valid = 1'b1; prod_in = 64'h0102_0304_0506_0708;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, out_data, out_be, out_last} !== {1'b1, 32'h0204_0608, 4'hF, 1'b0}) begin
      n_bad++; $display("FAIL s8_word0: got vld=%b data=%h be=%h last=%b, want 1 02040608 f 0",
                        out_valid, out_data, out_be, out_last);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL s8_ready: got %b, want 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, out_data, out_be, out_last} !== {1'b1, 32'h0000_0608, 4'b0011, 1'b1}) begin
      n_bad++; $display("FAIL s8_word1: got vld=%b data=%h be=%h last=%b, want 1 00000608 3 1",
                        out_valid, out_data, out_be, out_last);
    end
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if ({done, busy, out_valid} !== 3'b100) begin
      n_bad++; $display("FAIL s8_done: got done=%b busy=%b vld=%b, want 1 0 0", done, busy, out_valid);
    end
  endtask

  task automatic test_backpressure;
    int n = 0;
    int m = 0;
    logic [31:0] exp_w;
    out_ready = 1'b0;
    do_start(9'd6, 2'b10, 1'b0);
    for (int c = 0; c < 8; c++) begin
      if (in_ready === 1'b1 && n < 6) begin
        in_valid = 1'b1; prod_in = {32'hFFFF_0000 + n, 32'h1000_0000 + n}; n++;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_cmp++;
    if (n !== 4) begin
      n_bad++; $display("FAIL bp_accepted: got %0d beats, want 4", n);
    end
    n_cmp++;
    if ({in_ready, out_valid, out_data} !== {1'b0, 1'b1, 32'h1000_0000}) begin
      n_bad++; $display("FAIL bp_held: got rdy=%b vld=%b data=%h, want 0 1 10000000",
                        in_ready, out_valid, out_data);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 40 && m < 6; c++) begin
      if (out_valid === 1'b1) begin
        exp_w = 32'h1000_0000 + m;
        n_cmp++;
        if ({out_data, out_be, out_last} !== {exp_w, 4'hF, (m == 5)}) begin
          n_bad++; $display("FAIL bp_word%0d: got data=%h be=%h last=%b, want %h f %b",
                            m, out_data, out_be, out_last, exp_w, (m == 5));
        end
        m++;
      end
      if (in_ready === 1'b1 && n < 6) begin
        in_valid = 1'b1; prod_in = {32'hFFFF_0000 + n, 32'h1000_0000 + n}; n++;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_cmp++;
    if (m !== 6) begin
      n_bad++; $display("FAIL bp_word_count: got %0d words before timeout, want 6", m);
    end
    n_cmp++;
    if ({done, busy, out_valid} !== 3'b100) begin
      n_bad++; $display("FAIL bp_done: got done=%b busy=%b vld=%b, want 1 0 0", done, busy, out_valid);
    end
  endtask

  task automatic test_vl_zero;
    logic seen = 1'b0;
    do_start(9'd0, 2'b00, 1'b0);
    n_cmp++;
    if ({done, busy, out_valid} !== 3'b100) begin
      n_bad++; $display("FAIL vl0_done: got done=%b busy=%b vld=%b, want 1 0 0", done, busy, out_valid);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++; $display("FAIL vl0_quiet: got activity=%b after done, want 0", seen);
    end
  endtask

  task automatic test_reset_mid;
    logic seen_done = 1'b0;
    out_ready = 1'b0;
    do_start(9'd8, 2'b10, 1'b0);
    in_valid = 1'b1; prod_in = 64'h0000_0000_AAAA_0001;
    @(negedge clk);
    prod_in = 64'h0000_0000_AAAA_0002;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if ({busy, out_valid, out_data} !== {1'b1, 1'b1, 32'hAAAA_0001}) begin
      n_bad++; $display("FAIL rst_mid_pre: got busy=%b vld=%b data=%h, want 1 1 aaaa0001",
                        busy, out_valid, out_data);
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, out_valid, out_data, out_be, out_last, busy, done} !== 41'h0) begin
      n_bad++; $display("FAIL rst_mid_outputs: got rdy=%b vld=%b data=%h be=%h last=%b busy=%b done=%b, want all 0",
                        in_ready, out_valid, out_data, out_be, out_last, busy, done);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done !== 1'b0) seen_done = 1'b1;
    end
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (done !== 1'b0) seen_done = 1'b1;
    end
    n_cmp++;
    if (seen_done !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_no_done: got done seen=%b, want 0", seen_done);
    end
    do_start(9'd1, 2'b01, 1'b0);
    in_valid = 1'b1; prod_in = 64'h0000_0000_ABCD_1234;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, out_data, out_be, out_last} !== {1'b1, 32'h0000_1234, 4'b0011, 1'b1}) begin
      n_bad++; $display("FAIL rst_mid_restart: got vld=%b data=%h be=%h last=%b, want 1 00001234 3 1",
                        out_valid, out_data, out_be, out_last);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if ({done, busy, out_valid} !== 3'b100) begin
      n_bad++; $display("FAIL rst_mid_done: got done=%b busy=%b vld=%b, want 1 0 0", done, busy, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_sew16_low();
    test_sew16_high();
    test_sew8_tail();
    test_backpressure();
    test_vl_zero();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
